// File: rtl/mux_4_arbiter.sv
// mux_4_arbiter: round-robin arbiter in front of a shared 4:1 mux.
// It grants one requester at a time and registers the selected word into a
// single output stage with a valid/ready handshake.
// Optional build macro: MUX_4_ARBITER_FIXED_PRIO_EN selects fixed priority
// (index 0 highest) in place of round-robin.
module mux_4_arbiter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [1:0]         sel
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [WIDTH-1:0] words [4];
    logic [1:0]       grant;
    logic             any_valid;
    logic             can_accept;
    logic             accept;

    // Unpack the flat request bus into one word per requester.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            words[i] = req_data[WIDTH*i +: WIDTH];
        end
    end

    // Search from ptr upward (mod 4); walking the offsets from high to low
    // lets the nearest valid requester overwrite any farther one.
    always_comb begin
        logic [1:0] idx;
        grant     = ptr_q;
        any_valid = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req_valid[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Handshake: the stage takes a word when empty or draining this cycle.
    always_comb begin
        can_accept = (state_q == StEmpty) || out_ready;
        accept     = any_valid && can_accept && !rst;
        req_ready  = accept ? (4'b0001 << grant) : 4'b0000;
    end

    // Next-state: a new accept wins over a plain drain.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (accept) begin
            state_d = StFull;
            sel_d   = grant;
            data_d  = words[grant];
`ifdef MUX_4_ARBITER_FIXED_PRIO_EN
            ptr_d   = 2'd0;
`else
            ptr_d   = grant + 2'd1;
`endif
        end else if (state_q == StFull && out_ready) begin
            state_d = StEmpty;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_mux_4_arbiter.sv
// tb_mux_4_arbiter: directed test-plan scenarios followed by randomized
// traffic, all checked against a transaction-level model of the arbiter.
module tb_mux_4_arbiter;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req_valid;
    logic [4*W-1:0] req_data;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     sel;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the output stage as a word slot plus a priority pointer.
    int m_full, m_data, m_sel, m_ptr;

    always #5 clk = ~clk;

    mux_4_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel       (sel)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: drive, check req_ready, advance model, check outputs.
    task automatic step(input logic r, input logic [3:0] v, input logic [4*W-1:0] d,
                        input logic ordy, output logic [3:0] granted);
        int g;
        logic [3:0] exp_ready;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        #1;
        g = model_grant(v);
        exp_ready = (!r && g >= 0 && (m_full == 0 || ordy)) ? 4'(1 << g) : 4'b0000;
        check("req_ready", int'(req_ready), int'(exp_ready));
        granted = exp_ready;
        if (r) begin
            m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        end else if (exp_ready != 0) begin
            m_full = 1;
            m_data = int'(d[g*W +: W]);
            m_sel  = g;
`ifndef MUX_4_ARBITER_FIXED_PRIO_EN
            m_ptr  = (g + 1) % 4;
`endif
        end else if (m_full == 1 && ordy) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), m_full);
        check("out_data", int'(out_data), m_data);
        check("sel", int'(sel), m_sel);
    endtask

    initial begin
        logic [3:0]     gnt;
        logic [3:0]     hv;
        logic [4*W-1:0] hd;
        logic [4*W-1:0] rr_data;
        m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        rr_data = {4'd1, 4'd0, 4'd1, 4'd0};

        // Reset with every requester asserting.
        repeat (2) step(1'b1, 4'b1111, rr_data, 1'b1, gnt);
        check("rst_ready", int'(gnt), 0);
        check("rst_out_valid", int'(out_valid), 0);

`ifndef MUX_4_ARBITER_FIXED_PRIO_EN
        // Round-robin streaming at full throughput.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b1111, rr_data, 1'b1, gnt);
            check("rr_sel", int'(sel), k % 4);
            check("rr_data", int'(out_data), k % 2);
            check("rr_valid", int'(out_valid), 1);
        end
        // Backpressure: stage frozen, then drain plus accept on one edge.
        repeat (3) begin
            step(1'b0, 4'b1111, rr_data, 1'b0, gnt);
            check("bp_ready", int'(gnt), 0);
            check("bp_sel", int'(sel), 0);
        end
        step(1'b0, 4'b1111, rr_data, 1'b1, gnt);
        check("bp_release_sel", int'(sel), 1);
        repeat (2) step(1'b0, 4'b1111, rr_data, 1'b1, gnt);
        check("pre_rst_sel", int'(sel), 3);
        // Reset while full with sel=3.
        step(1'b1, 4'b1111, rr_data, 1'b1, gnt);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_sel", int'(sel), 0);
        step(1'b0, 4'b1111, rr_data, 1'b1, gnt);
        check("post_rst_grant", int'(gnt), 1);
`else
        // Fixed priority: index 0 always wins, then 1 once 0 drops.
        repeat (4) begin
            step(1'b0, 4'b1111, rr_data, 1'b1, gnt);
            check("fp_sel", int'(sel), 0);
        end
        step(1'b0, 4'b1110, rr_data, 1'b1, gnt);
        check("fp_sel_b", int'(sel), 1);
`endif

        // Single request on input c.
        step(1'b1, 4'b0000, '0, 1'b1, gnt);
        step(1'b0, 4'b0100, {4'd0, 4'd1, 4'd0, 4'd0}, 1'b1, gnt);
        check("single_ready", int'(gnt), 4);
        check("single_sel", int'(sel), 2);
        check("single_data", int'(out_data), 1);
        step(1'b0, 4'b0000, '0, 1'b1, gnt);
        check("drain_valid", int'(out_valid), 0);
        check("drain_hold_sel", int'(sel), 2);

        // Randomized traffic: requesters hold until served or drop at random.
        hv = '0; hd = '0; gnt = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) hv[i] = 1'b0;
                if (hv[i]) begin
                    if ($urandom_range(9) == 0) hv[i] = 1'b0;
                end else if ($urandom_range(1) == 1) begin
                    hv[i] = 1'b1;
                    hd[i*W +: W] = W'($urandom);
                end
            end
            step(($urandom_range(49) == 0), hv, hd, ($urandom_range(3) != 0), gnt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
